resol_ctrl: RTL and testbench

//  Sequences a display resolution change for the sync generator. Takes a resolution

---
 rtl/resol_ctrl_pkg.sv | 9 +
 rtl/resol_ctrl_timer.sv | 19 +
 rtl/resol_ctrl.sv | 134 +++++++++++++
 tb/tb_resol_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/resol_ctrl_pkg.sv
// resol_ctrl_pkg: FSM states, resolution codes and counter width shared by resol_ctrl
package resol_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_FRAME, S_RESET_HOLD, S_SETTLE, S_BLANK} state_t;
  localparam logic [1:0] RES_VGA = 2'd0;
  localparam logic [1:0] RES_SVGA = 2'd1;
  localparam logic [1:0] RES_XGA = 2'd2;
  localparam logic [1:0] RES_SXGA = 2'd3;
  localparam int CW_DEF = 16;
endpackage

// File: rtl/resol_ctrl_timer.sv
// resol_ctrl_timer: saturating up-counter with clear/enable and >= threshold compare
module resol_ctrl_timer
  import resol_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          DCLK,
  input  logic          DRST,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] thr,
  output logic          ge
);
  logic [CW-1:0] cnt;
  always_ff @(posedge DCLK)
    if (DRST || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign ge = cnt >= thr;
endmodule

// File: rtl/resol_ctrl.sv
// resol_ctrl: sequences a syncgen resolution change (frame wait, reset hold, settle, blank).
// Define RESOL_CTRL_TIMEOUT_EN to bound the frame wait by TIMEOUT_CYC cycles.
module resol_ctrl
  import resol_ctrl_pkg::*;
#(
  parameter logic [1:0] RESOL_INIT = RES_VGA,
  parameter int RST_CYC = 16,
  parameter int SETTLE_CYC = 1024,
  parameter int BLANK_FRAMES = 2,
  parameter int CW = CW_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       DCLK,
  input  logic       DRST,
  input  logic       REQ_VALID,
  input  logic [1:0] RESOL_REQ,
  input  logic       VRSTART,
  input  logic       CLK_LOCKED,
  output logic [1:0] RESOL,
  output logic       SG_RST,
  output logic       DSP_BLANK,
  output logic       BUSY,
  output logic       REQ_ACK,
  output logic       TIMEOUT
);
  // thresholds are last-cycle indices: the timer reads 0 on the first cycle of a state
  localparam logic [CW-1:0] THR_HOLD = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] THR_SETTLE = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] THR_BLANK = CW'(BLANK_FRAMES == 0 ? 0 : BLANK_FRAMES - 1);
  localparam logic [CW-1:0] THR_TMO = CW'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic [1:0] resol_n, target, target_n, pend_r, pend_r_n, nxt_req;
  logic sg_rst_n, blank_n, pend_v, pend_v_n, vrstart_q, fe, ge, go;
  logic [CW-1:0] thr;
  assign fe = VRSTART & ~vrstart_q;
  assign nxt_req = REQ_VALID ? RESOL_REQ : pend_r;
  assign thr = state == S_RESET_HOLD ? THR_HOLD :
               state == S_SETTLE ? THR_SETTLE :
               state == S_BLANK ? THR_BLANK : THR_TMO;
`ifdef RESOL_CTRL_TIMEOUT_EN
  logic tmo, tmo_n;
  assign go = fe | ge;
  assign TIMEOUT = tmo;
`else
  assign go = fe;
  assign TIMEOUT = 1'b0;
`endif
  resol_ctrl_timer #(.CW(CW)) u_timer (
    .DCLK(DCLK),
    .DRST(DRST),
    .clr (state_n != state),
    .en  (state == S_BLANK ? fe : 1'b1),
    .thr (thr),
    .ge  (ge)
  );
  always_comb begin
    state_n = state;
    resol_n = RESOL;
    sg_rst_n = SG_RST;
    blank_n = DSP_BLANK;
    target_n = target;
    pend_v_n = pend_v;
    pend_r_n = pend_r;
`ifdef RESOL_CTRL_TIMEOUT_EN
    tmo_n = tmo;
`endif
    if (REQ_VALID && state != S_IDLE) begin
      pend_v_n = 1'b1;
      pend_r_n = RESOL_REQ;
    end
    case (state)
      S_IDLE:
        if (REQ_VALID || pend_v) begin
          pend_v_n = 1'b0;
          if (nxt_req != RESOL) begin
            target_n = nxt_req;
            state_n = S_WAIT_FRAME;
          end
        end
      S_WAIT_FRAME:
        if (go) begin
          state_n = S_RESET_HOLD;
          resol_n = target;
          sg_rst_n = 1'b1;
          blank_n = 1'b1;
`ifdef RESOL_CTRL_TIMEOUT_EN
          tmo_n = tmo | ~fe;
`endif
        end
      S_RESET_HOLD: if (ge) state_n = S_SETTLE;
      S_SETTLE:
        if (ge && CLK_LOCKED) begin
          sg_rst_n = 1'b0;
          blank_n = BLANK_FRAMES != 0;
          state_n = BLANK_FRAMES == 0 ? S_IDLE : S_BLANK;
        end
      S_BLANK:
        if (fe && ge) begin
          blank_n = 1'b0;
          state_n = S_IDLE;
        end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge DCLK)
    if (DRST) begin
      state <= S_RESET_HOLD;
      RESOL <= RESOL_INIT;
      SG_RST <= 1'b1;
      DSP_BLANK <= 1'b1;
      BUSY <= 1'b1;
      REQ_ACK <= 1'b0;
      target <= RESOL_INIT;
      pend_v <= 1'b0;
      pend_r <= RESOL_INIT;
      vrstart_q <= 1'b0;
    end else begin
      state <= state_n;
      RESOL <= resol_n;
      SG_RST <= sg_rst_n;
      DSP_BLANK <= blank_n;
      BUSY <= state_n != S_IDLE;
      REQ_ACK <= REQ_VALID;
      target <= target_n;
      pend_v <= pend_v_n;
      pend_r <= pend_r_n;
      vrstart_q <= VRSTART;
    end
`ifdef RESOL_CTRL_TIMEOUT_EN
  always_ff @(posedge DCLK)
    if (DRST) tmo <= 1'b0;
    else tmo <= tmo_n;
`endif
endmodule

// File: tb/tb_resol_ctrl.sv
// tb_resol_ctrl: directed bench for resol_ctrl with a resolution scoreboard queue
module tb_resol_ctrl;
  localparam int RST_CYC = 4;
  localparam int SETTLE_CYC = 8;
  localparam int TIMEOUT_CYC = 100;
  logic DCLK = 0, DRST, REQ_VALID, VRSTART, CLK_LOCKED;
  logic [1:0] RESOL_REQ, RESOL;
  logic SG_RST, DSP_BLANK, BUSY, REQ_ACK, TIMEOUT;
  int n_chk = 0, n_fail = 0, n;
  logic [1:0] exp_q[$];
  logic [1:0] exp_r;
  always #5 DCLK = ~DCLK;
  resol_ctrl #(
    .RESOL_INIT  (2'd0),
    .RST_CYC     (RST_CYC),
    .SETTLE_CYC  (SETTLE_CYC),
    .BLANK_FRAMES(2),
    .CW          (16),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .DCLK      (DCLK),
    .DRST      (DRST),
    .REQ_VALID (REQ_VALID),
    .RESOL_REQ (RESOL_REQ),
    .VRSTART   (VRSTART),
    .CLK_LOCKED(CLK_LOCKED),
    .RESOL     (RESOL),
    .SG_RST    (SG_RST),
    .DSP_BLANK (DSP_BLANK),
    .BUSY      (BUSY),
    .REQ_ACK   (REQ_ACK),
    .TIMEOUT   (TIMEOUT)
  );
  task automatic tick;
    @(posedge DCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic fe_edge;
    VRSTART = 0;
    tick;
    VRSTART = 1;
    tick;
    VRSTART = 0;
  endtask
  task automatic wait_sg(input logic v, output int cnt);
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (SG_RST !== v && cnt < 1000);
  endtask
  task automatic request(input logic [1:0] r);
    REQ_VALID = 1;
    RESOL_REQ = r;
    tick;
    REQ_VALID = 0;
    chk("req_ack", REQ_ACK, 1);
  endtask
  task automatic run_seq(input int lock_low);
    int c;
    fe_edge;
    n_chk++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed %0d expected >0", exp_q.size());
    end
    exp_r = exp_q.size() > 0 ? exp_q.pop_front() : 2'bxx;
    chk("seq_resol", RESOL, exp_r);
    chk("seq_sg_rst_on", SG_RST, 1);
    chk("seq_blank_on", DSP_BLANK, 1);
    if (lock_low == 0) begin
      wait_sg(0, c);
      chk("seq_sg_rst_len", c, RST_CYC + SETTLE_CYC);
    end else begin
      CLK_LOCKED = 0;
      repeat (lock_low) tick;
      chk("unlock_sg_rst_held", SG_RST, 1);
      chk("unlock_busy", BUSY, 1);
      CLK_LOCKED = 1;
      tick;
      chk("lock_sg_rst_rel", SG_RST, 0);
    end
    fe_edge;
    chk("blank_frame1", DSP_BLANK, 1);
    fe_edge;
    chk("blank_frame2", DSP_BLANK, 0);
    chk("seq_idle", BUSY, 0);
  endtask
  initial begin
    DRST = 1;
    REQ_VALID = 0;
    RESOL_REQ = 0;
    VRSTART = 0;
    CLK_LOCKED = 1;
    repeat (3) tick;
    chk("rst_resol", RESOL, 0);
    chk("rst_sg_rst", SG_RST, 1);
    chk("rst_blank", DSP_BLANK, 1);
    chk("rst_busy", BUSY, 1);
    chk("rst_ack", REQ_ACK, 0);
    chk("rst_timeout", TIMEOUT, 0);
    DRST = 0;
    wait_sg(0, n);
    chk("init_sg_rst_len", n, RST_CYC + SETTLE_CYC);
    fe_edge;
    chk("init_blank1", DSP_BLANK, 1);
    fe_edge;
    chk("init_blank2", DSP_BLANK, 0);
    chk("init_idle", BUSY, 0);
    request(2);
    exp_q.push_back(2);
    chk("req2_busy", BUSY, 1);
    repeat (3) tick;
    chk("req2_ack_pulse", REQ_ACK, 0);
    chk("req2_resol_hold", RESOL, 0);
    chk("req2_sg_rst_low", SG_RST, 0);
    chk("req2_blank_low", DSP_BLANK, 0);
    run_seq(0);
    request(1);
    exp_q.push_back(1);
    run_seq(500);
    chk("lock_resol", RESOL, 1);
    request(0);
    exp_q.push_back(0);
    request(1);
    request(3);
    exp_q.push_back(3);
    run_seq(0);
    tick;
    chk("pend_busy", BUSY, 1);
    chk("pend_no_ack", REQ_ACK, 0);
    run_seq(0);
    request(3);
    chk("same_idle", BUSY, 0);
    repeat (3) tick;
    chk("same_still_idle", BUSY, 0);
    chk("same_resol", RESOL, 3);
    request(1);
    fe_edge;
    wait_sg(0, n);
    chk("abort_in_blank", DSP_BLANK, 1);
    request(2);
    DRST = 1;
    tick;
    chk("abort_resol", RESOL, 0);
    chk("abort_sg_rst", SG_RST, 1);
    chk("abort_blank", DSP_BLANK, 1);
    chk("abort_busy", BUSY, 1);
    chk("abort_ack", REQ_ACK, 0);
    chk("abort_timeout", TIMEOUT, 0);
    DRST = 0;
    wait_sg(0, n);
    chk("abort_sg_rst_len", n, RST_CYC + SETTLE_CYC);
    fe_edge;
    fe_edge;
    repeat (3) tick;
    chk("abort_pend_lost", BUSY, 0);
    request(2);
`ifdef RESOL_CTRL_TIMEOUT_EN
    wait_sg(1, n);
    chk("tmo_cycles", n, TIMEOUT_CYC);
    chk("tmo_flag", TIMEOUT, 1);
    chk("tmo_resol", RESOL, 2);
    wait_sg(0, n);
    repeat (3) tick;
    chk("tmo_sticky", TIMEOUT, 1);
`else
    repeat (150) tick;
    chk("wait_busy", BUSY, 1);
    chk("wait_sg_rst", SG_RST, 0);
    chk("wait_resol", RESOL, 0);
    chk("wait_timeout", TIMEOUT, 0);
`endif
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
